// File: rtl/avl_symbol_writer.sv
// avl_symbol_writer: Avalon-MM initiator that places 16-bit symbols into an
// 80x60 symbol VRAM (two symbols per 32-bit word) by read-modify-write, and
// clears the whole VRAM on request.
// Latency: place = 3+RD_LAT cycles accept-to-ready (+1+RD_LAT with read-back),
//          clear = 2401 cycles, dropped command = 1 cycle.
// Backpressure: cmd_ready is high only in IDLE; a command is consumed on
//          cmd_valid && cmd_ready.
//
// Ports:
//   Clk, Reset           clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_op               00 place, 01 clear, 1x reserved (dropped, err pulse)
//   cmd_col/cmd_row      target cell (col 0..N_COLS-1, row 0..N_ROWS-1)
//   cmd_symbol           16-bit symbol to place
//   busy                 high in any non-IDLE state
//   err                  one-cycle pulse on a dropped command (or read-back miscompare)
//   AVL_*                Avalon-MM initiator; AVL_READDATA valid RD_LAT cycles
//                        after the AVL_READ strobe
//
// Optional feature macro: SYMBOL_WRITER_READBACK_EN -- after each place write
// the word is read back and compared; a miscompare pulses err.

module avl_symbol_writer #(
    parameter int          RD_LAT   = 1,
    parameter int          N_COLS   = 80,
    parameter int          N_ROWS   = 60,
    parameter logic [31:0] CLR_WORD = 32'h0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [6:0]  cmd_col,
    input  logic [5:0]  cmd_row,
    input  logic [15:0] cmd_symbol,
    output logic        busy,
    output logic        err,
    output logic        AVL_CS,
    output logic        AVL_READ,
    output logic        AVL_WRITE,
    output logic [3:0]  AVL_BYTE_EN,
    output logic [12:0] AVL_ADDR,
    output logic [31:0] AVL_WRITEDATA,
    input  logic [31:0] AVL_READDATA
);

    // Two symbols per word; an odd column count still gets a full word per row.
    localparam int          WORDS_PER_ROW = (N_COLS + 1) / 2;
    localparam int          N_WORDS       = WORDS_PER_ROW * N_ROWS;
    localparam logic [12:0] LAST_WORD     = 13'(N_WORDS - 1);
    localparam logic [12:0] ROW_STRIDE    = 13'(WORDS_PER_ROW);
    localparam logic [6:0]  COL_LIM       = 7'(N_COLS);
    localparam logic [6:0]  ROW_LIM       = 7'(N_ROWS);
    localparam logic [2:0]  WAIT_LAST     = 3'(RD_LAT - 1);

    localparam logic [1:0]  OP_PLACE = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WAIT  = 3'd2,
        S_WR    = 3'd3,
        S_CLR   = 3'd4
`ifdef SYMBOL_WRITER_READBACK_EN
        ,
        S_VRD   = 3'd5,
        S_VWAIT = 3'd6
`endif
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [12:0] cmd_addr;
    logic        cmd_drop;
    logic        accept;
    logic        wait_last;
    logic        clr_last;

    logic [2:0]  wait_cnt;
    logic        col_odd;
    logic [15:0] sym_q;

    // Word address of the addressed cell; col[0] picks the half later.
    assign cmd_addr = 13'(cmd_row) * ROW_STRIDE + 13'(cmd_col[6:1]);

    assign cmd_drop = cmd_op[1]
                    || (cmd_col >= COL_LIM)
                    || ({1'b0, cmd_row} >= ROW_LIM);

    assign accept    = cmd_valid && cmd_ready;
    assign wait_last = (wait_cnt == WAIT_LAST);
    // During CLR the address register doubles as the word counter.
    assign clr_last  = (AVL_ADDR == LAST_WORD);

    assign AVL_CS      = AVL_READ || AVL_WRITE;
    assign AVL_BYTE_EN = {4{AVL_CS}};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        AVL_READ   = 1'b0;
        AVL_WRITE  = 1'b0;

        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                // Dropped commands are consumed but stay in IDLE.
                if (cmd_valid && !cmd_drop) begin
                    if (cmd_op == OP_PLACE) begin
                        next_state = S_RD;
                    end else begin
                        next_state = S_CLR;
                    end
                end
            end

            S_RD: begin
                AVL_READ   = 1'b1;
                next_state = S_WAIT;
            end

            S_WAIT: begin
                if (wait_last) begin
                    next_state = S_WR;
                end
            end

            S_WR: begin
                AVL_WRITE  = 1'b1;
`ifdef SYMBOL_WRITER_READBACK_EN
                next_state = S_VRD;
`else
                next_state = S_IDLE;
`endif
            end

`ifdef SYMBOL_WRITER_READBACK_EN
            S_VRD: begin
                AVL_READ   = 1'b1;
                next_state = S_VWAIT;
            end

            S_VWAIT: begin
                if (wait_last) begin
                    next_state = S_IDLE;
                end
            end
`endif

            S_CLR: begin
                AVL_WRITE = 1'b1;
                if (clr_last) begin
                    next_state = S_IDLE;
                end
            end

            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: address/data registers, read-latency counter, err pulse
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            AVL_ADDR      <= 13'd0;
            AVL_WRITEDATA <= 32'd0;
            col_odd       <= 1'b0;
            sym_q         <= 16'd0;
            wait_cnt      <= 3'd0;
            err           <= 1'b0;
        end else begin
            err <= 1'b0;

            if (accept) begin
                if (cmd_drop) begin
                    err <= 1'b1;
                end else if (cmd_op == OP_PLACE) begin
                    AVL_ADDR <= cmd_addr;
                    col_odd  <= cmd_col[0];
                    sym_q    <= cmd_symbol;
                end else begin
                    AVL_ADDR      <= 13'd0;
                    AVL_WRITEDATA <= CLR_WORD;
                end
            end

            // Counter restarts on every read strobe and counts the wait cycles.
            if (AVL_READ) begin
                wait_cnt <= 3'd0;
            end else if (state == S_WAIT
`ifdef SYMBOL_WRITER_READBACK_EN
                         || state == S_VWAIT
`endif
                        ) begin
                wait_cnt <= wait_cnt + 3'd1;
            end

            // Merge on the cycle the read data is valid; the other half is kept.
            if (state == S_WAIT && wait_last) begin
                if (col_odd) begin
                    AVL_WRITEDATA <= {sym_q, AVL_READDATA[15:0]};
                end else begin
                    AVL_WRITEDATA <= {AVL_READDATA[31:16], sym_q};
                end
            end

            // Address stops at the last word; it never wraps.
            if (state == S_CLR && !clr_last) begin
                AVL_ADDR <= AVL_ADDR + 13'd1;
            end

`ifdef SYMBOL_WRITER_READBACK_EN
            // AVL_WRITEDATA still holds the written word during read-back.
            if (state == S_VWAIT && wait_last && (AVL_READDATA != AVL_WRITEDATA)) begin
                err <= 1'b1;
            end
`endif
        end
    end

endmodule
